// File: rtl/tm_quanta_ctrl.sv
// -----------------------------------------------------------------------------
// tm_quanta_ctrl
//
// Quanta sequencer for a set of timing-model units. A run is requested with
// dbg_start. Each quanta begins with a one-cycle quanta_start broadcast. The
// quanta ends once every unit enabled in the latched mask has reported
// unit_done. Back-to-back quanta are separated by exactly one cycle. A run ends
// for one of three reasons:
//   - dbg_stop was seen (the current quanta is finished first),
//   - the configured quanta limit is reached,
//   - the per-quanta watchdog expires, which also sets the sticky wdt_err.
//
// Ports
//   gclk, rst      clock and synchronous active-high reset
//   dbg_start      one-cycle run request (accepted only in IDLE)
//   dbg_stop       one-cycle halt request, effective at the next quanta boundary
//   cfg_we/addr/wdata
//                  config writes, applied one cycle after cfg_we:
//                    0: unit_mask
//                    1: quanta_limit (0 = unlimited)
//                    2: wdt_limit    (0 = disabled)
//                    3: clear quanta_count and wdt_err
//   unit_done      per-unit quanta_done pulses
//   quanta_start   registered tm_START broadcast (high for the ISSUE cycle)
//   quanta_count   completed quanta since reset or the last clear
//   running        registered, high while in ISSUE or WAIT
//   wdt_err        sticky watchdog-timeout flag
//   fsm_state      current FSM state, for debug (0 IDLE, 1 ISSUE, 2 WAIT)
//
// There is no valid/ready handshake here. All control inputs are single-cycle
// pulses, and they are sampled on the rising edge of gclk.
// -----------------------------------------------------------------------------
module tm_quanta_ctrl #(
  parameter int NUNIT  = 2,
  parameter int WDTMSB = 23
) (
  input  logic             gclk,
  input  logic             rst,
  input  logic             dbg_start,
  input  logic             dbg_stop,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  input  logic [NUNIT-1:0] unit_done,
  output logic             quanta_start,
  output logic [31:0]      quanta_count,
  output logic             running,
  output logic             wdt_err,
  output logic [1:0]       fsm_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [NUNIT-1:0] unit_mask_q, unit_mask_d;
  logic [NUNIT-1:0] active_mask_q, active_mask_d;
  logic [NUNIT-1:0] done_vec_q, done_vec_d;
  logic [31:0]      quanta_limit_q, quanta_limit_d;
  logic [WDTMSB:0]  wdt_limit_q, wdt_limit_d;
  logic [WDTMSB:0]  wdt_cnt_q, wdt_cnt_d;
  logic [31:0]      quanta_count_q, quanta_count_d;
  logic             stop_pend_q, stop_pend_d;
  logic             wdt_err_q, wdt_err_d;
  logic             quanta_start_q, quanta_start_d;
  logic             running_q, running_d;

  // Combinational helpers for the WAIT decision.
  logic [NUNIT-1:0] done_next;
  logic             all_done;
  logic [31:0]      count_inc;
  logic             limit_hit;
  logic [WDTMSB:0]  wdt_inc;
  logic             wdt_hit;
  logic             stop_now;

  // Only the low cfg_wdata bits feed narrow registers. This reduction keeps
  // the remaining bits visibly consumed.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^cfg_wdata;

  always_comb begin
    state_d        = state_q;
    unit_mask_d    = unit_mask_q;
    active_mask_d  = active_mask_q;
    done_vec_d     = done_vec_q;
    quanta_limit_d = quanta_limit_q;
    wdt_limit_d    = wdt_limit_q;
    wdt_cnt_d      = wdt_cnt_q;
    quanta_count_d = quanta_count_q;
    wdt_err_d      = wdt_err_q;

    // done_next includes this cycle's pulses, so completion is not delayed a cycle.
    done_next = done_vec_q | (unit_done & active_mask_q);
    all_done  = &(done_next | ~active_mask_q);
    count_inc = quanta_count_q + 32'd1;
    limit_hit = (quanta_limit_q != 32'd0) && (count_inc >= quanta_limit_q);
    wdt_inc   = wdt_cnt_q + {{WDTMSB{1'b0}}, 1'b1};
    wdt_hit   = (wdt_limit_q != '0) && (wdt_inc == wdt_limit_q);
    // A stop arriving in the completion cycle itself still ends the run.
    stop_now  = stop_pend_q | dbg_stop;

    case (state_q)
      ST_IDLE: begin
        // A stop in the same cycle wins over start.
        if (dbg_start && !dbg_stop && (|unit_mask_q)) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        active_mask_d = unit_mask_q;
        // Pulses that land in the ISSUE cycle are kept: set beats clear.
        done_vec_d    = unit_done & unit_mask_q;
        wdt_cnt_d     = '0;
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        done_vec_d = done_next;
        if (all_done) begin
          quanta_count_d = count_inc;
          state_d        = (stop_now || limit_hit) ? ST_IDLE : ST_ISSUE;
        end else if (wdt_hit) begin
          wdt_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wdt_cnt_d = wdt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Config writes land next cycle. Mask and limit changes only take hold
    // at the next ISSUE or completion. The clear overrides a same-cycle
    // increment or timeout.
    if (cfg_we) begin
      case (cfg_addr)
        2'd0: unit_mask_d    = cfg_wdata[NUNIT-1:0];
        2'd1: quanta_limit_d = cfg_wdata;
        2'd2: wdt_limit_d    = cfg_wdata[WDTMSB:0];
        default: begin
          quanta_count_d = '0;
          wdt_err_d      = 1'b0;
        end
      endcase
    end

    // Being in (or entering) IDLE clears any pending stop.
    stop_pend_d    = (state_d == ST_IDLE) ? 1'b0 : (stop_pend_q | dbg_stop);
    quanta_start_d = (state_d == ST_ISSUE);
    running_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      unit_mask_q    <= '1;
      active_mask_q  <= '0;
      done_vec_q     <= '0;
      quanta_limit_q <= '0;
      wdt_limit_q    <= '0;
      wdt_cnt_q      <= '0;
      quanta_count_q <= '0;
      stop_pend_q    <= 1'b0;
      wdt_err_q      <= 1'b0;
      quanta_start_q <= 1'b0;
      running_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      unit_mask_q    <= unit_mask_d;
      active_mask_q  <= active_mask_d;
      done_vec_q     <= done_vec_d;
      quanta_limit_q <= quanta_limit_d;
      wdt_limit_q    <= wdt_limit_d;
      wdt_cnt_q      <= wdt_cnt_d;
      quanta_count_q <= quanta_count_d;
      stop_pend_q    <= stop_pend_d;
      wdt_err_q      <= wdt_err_d;
      quanta_start_q <= quanta_start_d;
      running_q      <= running_d;
    end
  end

  assign quanta_start = quanta_start_q;
  assign quanta_count = quanta_count_q;
  assign running      = running_q;
  assign wdt_err      = wdt_err_q;
  assign fsm_state    = state_q;

endmodule

// File: doc/tm_quanta_ctrl.md
TM_QUANTA_CTRL -- requirements
Module: tm_quanta_ctrl

Interface
REQ-001 SHALL have parameter NUNIT, default 2, number of timing-model units under quanta control.
REQ-002 SHALL have parameter WDTMSB, default 23, MSB of the per-quanta watchdog counter.
REQ-003 SHALL have port gclk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port dbg_start  in  1  one-cycle pulse requesting a simulation run.
REQ-006 SHALL have port dbg_stop  in  1  one-cycle pulse requesting a halt at the next quanta boundary.
REQ-007 SHALL have port cfg_we  in  1  configuration write strobe.
REQ-008 SHALL have port cfg_addr  in  2  configuration word address.
REQ-009 SHALL have port cfg_wdata  in  32  configuration write data.
REQ-010 SHALL have port unit_done  in  NUNIT  per-unit quanta_done pulses.
REQ-011 SHALL have port quanta_start  out  1  one-cycle tm_START broadcast to all units.
REQ-012 SHALL have port quanta_count  out  32  completed quanta since last clear.
REQ-013 SHALL have port running  out  1  high while in ISSUE or WAIT.
REQ-014 SHALL have port wdt_err  out  1  sticky watchdog-timeout flag.

Function
REQ-015 SHALL implement config registers: addr0 unit_mask[NUNIT-1:0]; addr1 quanta_limit[31:0] (0 = unlimited); addr2 wdt_limit[WDTMSB:0]; addr3 write of any value clears quanta_count and wdt_err.
REQ-016 SHALL apply a config write in the cycle after cfg_we, with no effect on the current quanta except addr3.
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-018 IDLE: on dbg_start, if unit_mask is nonzero, go to ISSUE; otherwise stay in IDLE.
REQ-019 ISSUE: lasts exactly one cycle; assert quanta_start; latch unit_mask into active_mask; clear done_vec and the watchdog counter; go to WAIT.
REQ-020 WAIT: set done_vec[i] on unit_done[i] when active_mask[i] is high; ignore unmasked units and duplicate pulses.
REQ-021 SHALL declare quanta complete in the cycle where (done_vec_next | ~active_mask) is all ones, where done_vec_next includes the current-cycle unit_done.
REQ-022 On completion, SHALL increment quanta_count by 1, wrapping 0xFFFFFFFF to 0.
REQ-023 On completion, SHALL go to IDLE if stop_pend is set, or if quanta_limit != 0 and the incremented count >= quanta_limit; otherwise SHALL go to ISSUE in the next cycle.
REQ-024 SHALL make the back-to-back quanta gap 1 cycle: the completion cycle is followed by quanta_start in the next cycle.
REQ-025 SHALL set stop_pend on dbg_stop in any state and clear it on entry to IDLE; dbg_stop in IDLE SHALL have no other effect.
REQ-026 If dbg_start and dbg_stop arrive in the same IDLE cycle, SHALL give stop priority and stay in IDLE.
REQ-027 SHALL ignore dbg_start while in ISSUE or WAIT.
REQ-028 SHALL increment the watchdog counter in every WAIT cycle without completion; when it equals wdt_limit and wdt_limit != 0, SHALL set wdt_err and go to IDLE without incrementing quanta_count.
REQ-029 SHALL capture unit_done pulses that arrive in the ISSUE cycle, with set taking priority over clear.
REQ-030 SHALL drive quanta_start and running as registered outputs.

Reset
REQ-031 On rst, SHALL set state IDLE, quanta_start 0, running 0, quanta_count 0, wdt_err 0, done_vec 0, stop_pend 0.
REQ-032 On rst, SHALL set unit_mask all ones, quanta_limit 0, wdt_limit 0.
REQ-033 SHALL abandon any in-flight quanta on rst asserted mid-WAIT and issue no quanta_start in the following cycle.

Verification
REQ-034 SHALL cover: NUNIT=2, quanta_limit=3, dbg_start, each unit answers 5 cycles after quanta_start -> exactly 3 quanta_start pulses, each 1 cycle after completion; quanta_count=3; running low afterwards.
REQ-035 SHALL cover: unit_mask=2'b01, only unit0 pulses -> completion on the unit0 pulse; unit1 pulses ignored.
REQ-036 SHALL cover: dbg_stop mid-WAIT with limit 0 -> current quanta completes, count +1, IDLE, no further quanta_start.
REQ-037 SHALL cover: wdt_limit=10, unit1 silent -> wdt_err=1 after 10 WAIT cycles, state IDLE, quanta_count unchanged; addr3 write clears both.
REQ-038 SHALL cover: unit_done of both units in the ISSUE cycle -> completion in the first WAIT cycle.
REQ-039 SHALL cover: rst mid-WAIT -> all outputs return to reset values in the next cycle.
